if_id_queue: RTL

- Instruction queue between the fetch stage and the decode stage of the 16-bit pipelined processor.
- Decouples fetch, which stalls on instruction-memory/cache misses, from decode, which stalls on hazards.
- Buffers up to DEPTH fetched instructions, each with its PC+2 value.
- Presents the oldest entry to decode and drops all entries on a branch/jump flush.
- Stops accepting instructions after a halt is enqueued.

---
 rtl/if_id_queue_if.sv | 30 +++
 rtl/if_id_queue.sv | 131 +++++++++++++
 2 files changed

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// The master side is the fetch/decode environment, the slave side is the queue.
interface if_id_queue_if #(
  parameter int PTR_W = 2
);
  // fetch side
  logic             if_valid;
  logic [15:0]      if_instr;
  logic [15:0]      if_pc_2;
  logic             if_ready;
  // decode side
  logic             id_stall;
  logic             id_valid;
  logic [15:0]      id_instr;
  logic [15:0]      id_pc_2;
  logic             id_halt;
  // control / status
  logic             flush;
  logic [PTR_W:0]   count;

  modport master (
    output if_valid, if_instr, if_pc_2, id_stall, flush,
    input  if_ready, id_valid, id_instr, id_pc_2, id_halt, count
  );

  modport slave (
    input  if_valid, if_instr, if_pc_2, id_stall, flush,
    output if_ready, id_valid, id_instr, id_pc_2, id_halt, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: show-ahead FIFO of {instr, pc_2} entries between
// fetch and decode, with whole-queue flush and fetch shut-off after a halt.
module if_id_queue #(
  parameter int          DEPTH     = 4,
  parameter int          PTR_W     = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave q
);

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO  = '0;
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = (PTR_W)'(1);

  // entry storage (contents are don't-care out of reset)
  logic [15:0] instr_mem_q [DEPTH];
  logic [15:0] instr_mem_d [DEPTH];
  logic [15:0] pc_mem_q    [DEPTH];
  logic [15:0] pc_mem_d    [DEPTH];

  // control state
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             halt_seen_q, halt_seen_d;

  // handshake terms
  logic        full_s;
  logic        empty_s;
  logic        ready_s;
  logic        push_s;
  logic        pop_s;
  logic        push_halt_s;
  logic [15:0] head_instr_s;
  logic [15:0] head_pc_s;

  // Opcode field [15:11] of all zeros marks a halt instruction.
  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[15:11] == 5'b00000);
  endfunction

  // Status, handshake and show-ahead head read; all derived from registered state.
  always_comb begin
    full_s  = (count_q == DEPTH_CNT);
    empty_s = (count_q == CNT_ZERO);
    // ready ignores a same-cycle pop so there is no path from id_stall
    ready_s = !full_s && !halt_seen_q;
    push_s  = q.if_valid && ready_s;
    pop_s   = !empty_s && !q.id_stall;
    push_halt_s = push_s && is_halt(q.if_instr);
    if (empty_s) begin
      head_instr_s = NOP_INSTR;
      head_pc_s    = 16'h0000;
    end else begin
      head_instr_s = instr_mem_q[head_q];
      head_pc_s    = pc_mem_q[head_q];
    end
  end

  // Next-state for pointers, occupancy, halt flag and entry storage.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    halt_seen_d = halt_seen_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (q.flush) begin
      // redirect: drop everything, including any same-cycle push/pop
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      halt_seen_d = 1'b0;
    end else begin
      if (push_s) begin
        instr_mem_d[tail_q] = q.if_instr;
        pc_mem_d[tail_q]    = q.if_pc_2;
        tail_d              = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (push_halt_s) begin
        halt_seen_d = 1'b1;
      end else begin
        halt_seen_d = halt_seen_q;
      end
    end
  end

  // Control-state registers with synchronous reset (reset outranks flush).
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  // Entry storage registers; no reset since contents are masked when empty.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  assign q.if_ready = ready_s;
  assign q.id_valid = !empty_s;
  assign q.id_instr = head_instr_s;
  assign q.id_pc_2  = head_pc_s;
  assign q.id_halt  = !empty_s && is_halt(head_instr_s);
  assign q.count    = count_q;

endmodule
